// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multicycle ARM-subset processor: walks each instruction
// through fetch/decode/execute/memory/writeback and emits datapath selects and write strobes.
module multicycle_control_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         op,
  input  logic [5:0]         funct,
  input  logic [3:0]         rd,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               next_pc,
  output logic               adr_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_control,
  output logic [1:0]         result_src,
  output logic               pcs,
  output logic               reg_w,
  output logic               mem_w,
  output logic [1:0]         flag_w,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  state_e state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:  if (mem_ready) state_q <= StDecode;
        StDecode: begin
          unique case (op)
            2'b00:   state_q <= funct[5] ? StExecI : StExecR;
            2'b01:   state_q <= StMemAdr;
            2'b10:   state_q <= StBranch;
            default: state_q <= StFetch;
          endcase
        end
        StMemAdr: state_q <= funct[0] ? StMemRd : StMemWr;
        StMemRd:  if (mem_ready) state_q <= StMemWb;
        StMemWr:  if (mem_ready) state_q <= StFetch;
        StExecR,
        StExecI:  state_q <= StAluWb;
        default:  state_q <= StFetch;
      endcase
    end
  end

  // ALU decode, only driven onto the outputs during the execute states
  logic [1:0] alu_dec;
  logic [1:0] flag_dec;
  logic       cmd_known;
  logic       cmd_arith;

  always_comb begin
    alu_dec   = 2'b00;
    cmd_known = 1'b1;
    cmd_arith = 1'b0;
    case (funct[4:1])
      4'b0100: begin alu_dec = 2'b00; cmd_arith = 1'b1; end
      4'b0010: begin alu_dec = 2'b01; cmd_arith = 1'b1; end
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      default: cmd_known = 1'b0;
    endcase
    flag_dec = cmd_known ? {funct[0], funct[0] & cmd_arith} : 2'b00;
  end

  // Outputs are forced low while reset is held, even though state reads as fetch
  always_comb begin
    ir_write    = 1'b0;
    next_pc     = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 2'b00;
    result_src  = 2'b00;
    pcs         = 1'b0;
    reg_w       = 1'b0;
    mem_w       = 1'b0;
    flag_w      = 2'b00;
    state_dbg   = STATE_W'(state_q);
    if (!rst) begin
      state_dbg = '0;
    end else begin
      case (state_q)
        StFetch: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          next_pc    = mem_ready;
        end
        StDecode: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
        end
        StMemAdr: alu_src_b = 2'b01;
        StMemRd:  adr_src = 1'b1;
        StMemWr: begin
          adr_src = 1'b1;
          mem_w   = mem_ready;
        end
        StMemWb: begin
          result_src = 2'b01;
          reg_w      = 1'b1;
          pcs        = (rd == 4'hF);
        end
        StExecR: begin
          alu_control = alu_dec;
          flag_w      = flag_dec;
        end
        StExecI: begin
          alu_src_b   = 2'b01;
          alu_control = alu_dec;
          flag_w      = flag_dec;
        end
        StAluWb: begin
          reg_w = 1'b1;
          pcs   = (rd == 4'hF);
        end
        StBranch: begin
          alu_src_b  = 2'b01;
          result_src = 2'b10;
          pcs        = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed per-cycle vector table, reset abort sequence,
// then random instruction streams checked against a route-queue reference model.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       mem_ready;
  logic       ir_write, next_pc, adr_src, alu_src_a, pcs, reg_w, mem_w;
  logic [1:0] alu_src_b, alu_control, result_src, flag_w;
  logic [3:0] state_dbg;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .rd         (rd),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .next_pc    (next_pc),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_control(alu_control),
    .result_src (result_src),
    .pcs        (pcs),
    .reg_w      (reg_w),
    .mem_w      (mem_w),
    .flag_w     (flag_w),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [14:0] act;
  assign act = {ir_write, next_pc, adr_src, alu_src_a, alu_src_b, alu_control, result_src,
                pcs, reg_w, mem_w, flag_w};

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        mr;
    logic [3:0]  st;
    logic [14:0] o;
  } vec_t;

  vec_t tv[$];

  function automatic logic [14:0] pk(int ir, int np, int adr, int a, int b, int ac, int rs,
                                     int pc, int rw, int mw, int fw);
    return {1'(ir), 1'(np), 1'(adr), 1'(a), 2'(b), 2'(ac), 2'(rs), 1'(pc), 1'(rw), 1'(mw),
            2'(fw)};
  endfunction

  task automatic add(int o_op, int o_funct, int o_rd, int o_mr, int o_st, logic [14:0] o);
    vec_t v;
    v.op = 2'(o_op); v.funct = 6'(o_funct); v.rd = 4'(o_rd); v.mr = 1'(o_mr);
    v.st = 4'(o_st); v.o = o;
    tv.push_back(v);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference outputs derived from the role of each step within an instruction
  function automatic logic [14:0] model_out(int code, logic [1:0] m_op, logic [5:0] m_f,
                                            logic [3:0] m_rd, logic mr);
    int cmd = int'(m_f[4:1]);
    int ac = 0;
    int fw = 0;
    int to_pc = (m_rd == 4'd15) ? 1 : 0;
    if (cmd == 4 || cmd == 2 || cmd == 0 || cmd == 12) begin
      ac = (cmd == 4) ? 0 : (cmd == 2) ? 1 : (cmd == 0) ? 2 : 3;
      fw = m_f[0] ? ((cmd == 4 || cmd == 2) ? 3 : 2) : 0;
    end
    case (code)
      0: return pk(mr, mr, 0, 1, 2, 0, 2, 0, 0, 0, 0);
      1: return pk(0, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0);
      2: return pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      3: return pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      4: return pk(0, 0, 0, 0, 0, 0, 1, to_pc, 1, 0, 0);
      5: return pk(0, 0, 1, 0, 0, 0, 0, 0, 0, mr, 0);
      6: return pk(0, 0, 0, 0, 0, ac, 0, 0, 0, 0, fw);
      7: return pk(0, 0, 0, 0, 1, ac, 0, 0, 0, 0, fw);
      8: return pk(0, 0, 0, 0, 0, 0, 0, to_pc, 1, 0, 0);
      9: return pk(0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0);
      default: return 15'h7fff;
    endcase
  endfunction

  initial begin
    logic [14:0] of1, of0;
    int m_code;
    int rq[$];

    of1 = pk(1, 1, 0, 1, 2, 0, 2, 0, 0, 0, 0);
    of0 = pk(0, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0);

    // ADD,S immediate -> 0,1,7,8
    add(0, 6'b101001, 3, 1, 0, of1);
    add(0, 6'b101001, 3, 1, 1, of0);
    add(0, 6'b101001, 3, 1, 7, pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3));
    add(0, 6'b101001, 3, 1, 8, pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // ORR register, no S
    add(0, 6'b011000, 2, 1, 0, of1);
    add(0, 6'b011000, 2, 0, 1, of0);
    add(0, 6'b011000, 2, 1, 6, pk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
    add(0, 6'b011000, 2, 1, 8, pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // SUB,S to R15
    add(0, 6'b000101, 15, 1, 0, of1);
    add(0, 6'b000101, 15, 1, 1, of0);
    add(0, 6'b000101, 15, 1, 6, pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3));
    add(0, 6'b000101, 15, 1, 8, pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    // AND,S: only N,Z flags
    add(0, 6'b000001, 4, 1, 0, of1);
    add(0, 6'b000001, 4, 1, 1, of0);
    add(0, 6'b000001, 4, 1, 6, pk(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 2));
    add(0, 6'b000001, 4, 1, 8, pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    // LDR to PC with one wait in MEMRD
    add(1, 6'b000001, 15, 1, 0, of1);
    add(1, 6'b000001, 15, 1, 1, of0);
    add(1, 6'b000001, 15, 1, 2, pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(1, 6'b000001, 15, 0, 3, pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 6'b000001, 15, 1, 3, pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 6'b000001, 15, 1, 4, pk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    // STR with two fetch stalls and one write wait
    add(1, 6'b000000, 5, 0, 0, of0);
    add(1, 6'b000000, 5, 0, 0, of0);
    add(1, 6'b000000, 5, 1, 0, of1);
    add(1, 6'b000000, 5, 1, 1, of0);
    add(1, 6'b000000, 5, 0, 2, pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(1, 6'b000000, 5, 0, 5, pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 6'b000000, 5, 1, 5, pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    // Branch, then illegal op
    add(2, 0, 0, 1, 0, of1);
    add(2, 0, 0, 1, 1, of0);
    add(2, 0, 0, 1, 9, pk(0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0));
    add(3, 0, 15, 1, 0, of1);
    add(3, 0, 15, 1, 1, of0);
    add(0, 0, 0, 0, 0, of0);

    // Reset state: outputs held low even with mem_ready high
    rst = 1'b0; op = 2'b00; funct = 6'd0; rd = 4'd0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_outputs", 32'(act), 32'd0);
    mem_ready = 1'b0;
    rst = 1'b1;

    foreach (tv[i]) begin
      @(posedge clk);
      #1;
      op = tv[i].op; funct = tv[i].funct; rd = tv[i].rd; mem_ready = tv[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(tv[i].st));
      chk($sformatf("vec%0d_out", i), 32'(act), 32'(tv[i].o));
    end

    // Abort an instruction in EXECR with an asynchronous reset
    @(posedge clk);
    #1;
    op = 2'b00; funct = 6'b001001; rd = 4'd7; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_pre_state", 32'(state_dbg), 32'd6);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_state", 32'(state_dbg), 32'd0);
    chk("abort_outputs", 32'(act), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_hold_outputs", 32'(act), 32'd0);
    mem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("release_state", 32'(state_dbg), 32'd0);
    chk("release_outputs", 32'(act), 32'(of1));
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Random instruction stream against the route-queue model
    m_code = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_code == 0) begin
        op = 2'($urandom_range(0, 3));
        funct = 6'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 3))
            0: funct[4:1] = 4'b0100;
            1: funct[4:1] = 4'b0010;
            2: funct[4:1] = 4'b0000;
            default: funct[4:1] = 4'b1100;
          endcase
        end
        rd = ($urandom_range(0, 1) == 1) ? 4'd15 : 4'($urandom);
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("rand_state", 32'(state_dbg), 32'(m_code));
      chk("rand_out", 32'(act), 32'(model_out(m_code, op, funct, rd, mem_ready)));
      @(posedge clk);
      if (m_code == 0) begin
        if (mem_ready) begin
          rq.delete();
          rq.push_back(1);
          case (op)
            2'b00: begin rq.push_back(funct[5] ? 7 : 6); rq.push_back(8); end
            2'b01: begin
              rq.push_back(2);
              if (funct[0]) begin rq.push_back(3); rq.push_back(4); end
              else rq.push_back(5);
            end
            2'b10: rq.push_back(9);
            default: ;
          endcase
          m_code = rq.pop_front();
        end
      end else if ((m_code == 3 || m_code == 5) && !mem_ready) begin
        m_code = m_code;
      end else begin
        m_code = (rq.size() > 0) ? rq.pop_front() : 0;
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
